// File: rtl/instr_packer_if.sv
// Instruction-field handshake and byte-write bus for instr_packer.
// The master side supplies encoded fields; the slave side packs them and writes bytes.
interface instr_packer_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [2:0]  funct3;
   logic        sub;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [11:0] imm;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [31:0] instr_word;
   logic        full;
   logic        err;

   modport master (
      output in_valid, fmt, funct3, sub, rs1, rs2, rd, imm,
      input  in_ready, wr_en, wr_addr, wr_data, instr_word, full, err
   );

   modport slave (
      input  in_valid, fmt, funct3, sub, rs1, rs2, rd, imm,
      output in_ready, wr_en, wr_addr, wr_data, instr_word, full, err
   );
endinterface

// File: rtl/instr_packer.sv
// Encodes RV32I-style instruction fields into a 32-bit word and writes it
// little-endian, one byte per cycle, into a 256-byte instruction memory.
module instr_packer #(
   parameter int unsigned BASE_ADDR = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   instr_packer_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StWrite, StFull} state_e;

   localparam logic [8:0] BaseAddr = 9'(BASE_ADDR);

   state_e      state;
   logic [1:0]  k;
   logic [1:0]  k_next;
   logic [8:0]  ptr;
   logic [8:0]  ptr_next;
   logic [31:0] enc;
   logic        legal;
   logic [31:0] word_q;
   logic        wr_en_q;
   logic [7:0]  wr_addr_q;
   logic [7:0]  wr_data_q;
   logic        full_q;
   logic        err_q;

   assign k_next   = k + 2'd1;
   assign ptr_next = ptr + 9'd4;

   always_comb begin
      enc   = 32'h0;
      legal = 1'b1;
      case (bus.fmt)
         3'd0: enc = {1'b0, bus.sub, 5'b00000, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0110011};
         3'd1: enc = {bus.imm, bus.rs1, bus.funct3, bus.rd, 7'b0010011};
         3'd2: enc = {bus.imm, bus.rs1, 3'b010, bus.rd, 7'b0000011};
         3'd3: enc = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], 7'b0100011};
         3'd4: enc = {bus.imm[11], bus.imm[9:4], bus.rs2, bus.rs1, bus.funct3,
                      bus.imm[3:0], bus.imm[10], 7'b1100011};
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         k         <= 2'd0;
         ptr       <= BaseAddr;
         word_q    <= 32'h0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 8'h0;
         wr_data_q <= 8'h0;
         full_q    <= 1'b0;
         err_q     <= 1'b0;
      end else if (clear) begin
         // Aborts any in-flight word; the last encoded word is kept.
         state   <= StIdle;
         k       <= 2'd0;
         ptr     <= BaseAddr;
         wr_en_q <= 1'b0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (bus.in_valid && !full_q) begin
                  if (legal) begin
                     word_q    <= enc;
                     state     <= StWrite;
                     k         <= 2'd0;
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= ptr[7:0];
                     wr_data_q <= enc[7:0];
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            StWrite: begin
               if (k == 2'd3) begin
                  wr_en_q <= 1'b0;
                  ptr     <= ptr_next;
                  if (ptr_next > 9'd252) begin
                     full_q <= 1'b1;
                     state  <= StFull;
                  end else begin
                     state <= StIdle;
                  end
               end else begin
                  k         <= k_next;
                  wr_addr_q <= ptr[7:0] + {6'b0, k_next};
                  wr_data_q <= word_q[{k_next, 3'b000} +: 8];
               end
            end
            StFull:  state <= StFull;
            default: state <= StIdle;
         endcase
      end
   end

   assign bus.in_ready   = (state == StIdle) && !full_q && !clear;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.instr_word = word_q;
   assign bus.full       = full_q;
   assign bus.err        = err_q;
endmodule
